// File: rtl/i2c_pkg.sv
// Shared types for the I2C master transaction engine.
// FSM state encoding, bit-quarter phases and ACK/NAK line levels.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_STOP
    } i2c_state_t;

    typedef enum logic [1:0] {
        PH_Q0,
        PH_Q1,
        PH_Q2,
        PH_Q3
    } i2c_phase_t;

    localparam logic ACK = 1'b0;
    localparam logic NAK = 1'b1;

endpackage

// File: rtl/i2c_tick_gen.sv
// SCL quarter-period prescaler with clock-stretch hold.
// Ports: HCLK, HRESETn, en, scl_in (synchronized), tick, phase.
import i2c_pkg::*;

module i2c_tick_gen #(
    parameter int CLK_DIV   = 250,
    parameter int DIV_WIDTH = 16
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       en,
    input  logic       scl_in,
    output logic       tick,
    output i2c_phase_t phase
);

    logic [DIV_WIDTH-1:0] cnt;
    logic                 hold;
    logic                 last;

    // After SCL is released, wait for it to really go high
    // so a stretching slave delays the high phase.
    assign hold = (phase == PH_Q2) && !scl_in;
    assign last = (cnt == DIV_WIDTH'(CLK_DIV - 1));
    assign tick = en && last && !hold;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt   <= '0;
            phase <= PH_Q0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= PH_Q0;
        end else if (hold) begin
            cnt   <= '0;
        end else if (last) begin
            cnt   <= '0;
            phase <= i2c_phase_t'(phase + 2'd1);
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// I2C master transaction engine: START, addr+R/W, 0..2 bytes, STOP.
// Ports: HCLK/HRESETn, request+shadowed args, SCL/SDA pads, RX bytes, event pulses, busy.
import i2c_pkg::*;

module i2c_master_ctrl #(
    parameter int CLK_DIV   = 250,
    parameter int DIV_WIDTH = 16
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       i_start,
    input  logic [6:0] i_slvaddr,
    input  logic       i_rnw,
    input  logic [1:0] i_nbytes,
    input  logic [7:0] i_byte_1,
    input  logic [7:0] i_byte_2,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_scl_oe,
    output logic       o_sda_oe,
    output logic [7:0] o_byte_1,
    output logic [7:0] o_byte_2,
    output logic       o_tra,
    output logic       o_rec,
    output logic       o_nak,
    output logic       o_busy
);

    i2c_state_t state;
    i2c_phase_t phase;
    logic       tick;
    logic [1:0] scl_ff, sda_ff;
    logic [6:0] sh_addr;
    logic       sh_rnw;
    logic [1:0] sh_n;
    logic [7:0] sh_b1, sh_b2;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       byte_idx;
    logic       ack_bit;
    logic       more;
    logic       sda_q0;

    i2c_tick_gen #(
        .CLK_DIV  (CLK_DIV),
        .DIV_WIDTH(DIV_WIDTH)
    ) u_tick (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .en     (state != ST_IDLE),
        .scl_in (scl_ff[1]),
        .tick   (tick),
        .phase  (phase)
    );

    assign more = !byte_idx && (sh_n == 2'd2);

    // SDA pull-down applied at Q0 of each bit slot
    always_comb begin
        sda_q0 = 1'b0;
        unique case (state)
            ST_ADDR, ST_WR_BYTE: sda_q0 = ~shreg[7];
            ST_RD_ACK:           sda_q0 = more ? ~ACK : ~NAK;
            ST_STOP:             sda_q0 = 1'b1;
            default:             sda_q0 = 1'b0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            scl_ff <= 2'b11;
            sda_ff <= 2'b11;
        end else begin
            scl_ff <= {scl_ff[0], i_scl};
            sda_ff <= {sda_ff[0], i_sda};
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            sh_addr  <= '0;
            sh_rnw   <= 1'b0;
            sh_n     <= '0;
            sh_b1    <= '0;
            sh_b2    <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_idx <= 1'b0;
            ack_bit  <= 1'b0;
            o_scl_oe <= 1'b0;
            o_sda_oe <= 1'b0;
            o_byte_1 <= '0;
            o_byte_2 <= '0;
            o_tra    <= 1'b0;
            o_rec    <= 1'b0;
            o_nak    <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            o_tra <= 1'b0;
            o_rec <= 1'b0;
            o_nak <= 1'b0;
            if (state == ST_IDLE) begin
                if (i_start) begin
                    sh_addr <= i_slvaddr;
                    sh_rnw  <= i_rnw;
                    sh_n    <= (i_nbytes == 2'd3) ? 2'd2 : i_nbytes;
                    sh_b1   <= i_byte_1;
                    sh_b2   <= i_byte_2;
                    state   <= ST_START;
                    o_busy  <= 1'b1;
                end
            end else if (tick) begin
                unique case (phase)
                    PH_Q0: o_sda_oe <= sda_q0;
                    PH_Q1: o_scl_oe <= 1'b0;
                    PH_Q2: begin
                        ack_bit <= sda_ff[1];
                        if (state == ST_RD_BYTE)
                            shreg <= {shreg[6:0], sda_ff[1]};
                        if (state == ST_START)
                            o_sda_oe <= 1'b1;
                        if (state == ST_STOP)
                            o_sda_oe <= 1'b0;
                    end
                    PH_Q3: begin
                        if (state != ST_STOP)
                            o_scl_oe <= 1'b1;
                        unique case (state)
                            ST_START: begin
                                shreg   <= {sh_addr, sh_rnw};
                                bit_cnt <= 3'd7;
                                state   <= ST_ADDR;
                            end
                            ST_ADDR, ST_WR_BYTE: begin
                                shreg   <= {shreg[6:0], 1'b0};
                                bit_cnt <= bit_cnt - 3'd1;
                                if (bit_cnt == 3'd0)
                                    state <= (state == ST_ADDR) ?
                                             ST_ADDR_ACK : ST_WR_ACK;
                            end
                            ST_RD_BYTE: begin
                                bit_cnt <= bit_cnt - 3'd1;
                                if (bit_cnt == 3'd0) begin
                                    o_rec <= 1'b1;
                                    state <= ST_RD_ACK;
                                    if (byte_idx) o_byte_2 <= shreg;
                                    else          o_byte_1 <= shreg;
                                end
                            end
                            ST_ADDR_ACK: begin
                                byte_idx <= 1'b0;
                                shreg    <= sh_b1;
                                if (ack_bit == NAK) begin
                                    o_nak <= 1'b1;
                                    state <= ST_STOP;
                                end else if (sh_n == 2'd0) begin
                                    state <= ST_STOP;
                                end else begin
                                    state <= sh_rnw ? ST_RD_BYTE : ST_WR_BYTE;
                                end
                            end
                            ST_WR_ACK: begin
                                if (ack_bit == NAK) begin
                                    o_nak <= 1'b1;
                                    state <= ST_STOP;
                                end else begin
                                    o_tra <= 1'b1;
                                    if (more) begin
                                        shreg    <= sh_b2;
                                        byte_idx <= 1'b1;
                                        state    <= ST_WR_BYTE;
                                    end else begin
                                        state <= ST_STOP;
                                    end
                                end
                            end
                            ST_RD_ACK: begin
                                if (more) begin
                                    byte_idx <= 1'b1;
                                    state    <= ST_RD_BYTE;
                                end else begin
                                    state <= ST_STOP;
                                end
                            end
                            ST_STOP: begin
                                state  <= ST_IDLE;
                                o_busy <= 1'b0;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: bus-level slave, wire decoder and transaction model.
// Table vectors, hand sequences (stretch, mid-byte reset) and random transactions.
module tb_i2c_master_ctrl;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       i_start = 1'b0;
    logic [6:0] i_slvaddr = '0;
    logic       i_rnw = 1'b0;
    logic [1:0] i_nbytes = '0;
    logic [7:0] i_byte_1 = '0;
    logic [7:0] i_byte_2 = '0;
    logic       o_scl_oe, o_sda_oe;
    logic [7:0] o_byte_1, o_byte_2;
    logic       o_tra, o_rec, o_nak, o_busy;
    logic       slv_scl = 1'b0;
    logic       slv_sda = 1'b0;
    wire        scl_w = !(o_scl_oe || slv_scl);
    wire        sda_w = !(o_sda_oe || slv_sda);

    always #5 HCLK = ~HCLK;

    i2c_master_ctrl #(.CLK_DIV(4), .DIV_WIDTH(8)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .i_start(i_start), .i_slvaddr(i_slvaddr), .i_rnw(i_rnw),
        .i_nbytes(i_nbytes), .i_byte_1(i_byte_1), .i_byte_2(i_byte_2),
        .i_scl(scl_w), .i_sda(sda_w),
        .o_scl_oe(o_scl_oe), .o_sda_oe(o_sda_oe),
        .o_byte_1(o_byte_1), .o_byte_2(o_byte_2),
        .o_tra(o_tra), .o_rec(o_rec), .o_nak(o_nak), .o_busy(o_busy)
    );

    typedef struct {
        logic [6:0] addr;
        logic       rnw;
        logic [1:0] nbytes;
        logic [7:0] b1, b2, rd1, rd2;
        logic       addr_nak;
        int         wr_nak;
        bit         poke;
        int         e_tra, e_rec, e_nak;
    } txn_t;

    int   n_cmp = 0, n_bad = 0;
    txn_t cur;
    int   cur_n = 0;
    int   k = 0, n_start = 0, n_stop = 0;
    int   n_tra = 0, n_rec = 0, n_nak = 0, n_ovl = 0;
    int   low_run = 0, max_low = 0;
    bit   stretch_arm = 0;
    logic scl_q = 1'b1, sda_q = 1'b1;
    logic bits[$];
    logic exp_bits[$];
    int   m_tra, m_rec, m_nak;
    logic [7:0] exp_b1 = '0, exp_b2 = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Wire-level view of the transaction as the spec describes it
    function automatic void build_model(input txn_t t);
        int n = (t.nbytes == 2'd3) ? 2 : int'(t.nbytes);
        logic [7:0] b;
        logic nk;
        exp_bits.delete();
        m_tra = 0; m_rec = 0; m_nak = 0;
        b = {t.addr, t.rnw};
        for (int j = 7; j >= 0; j--) exp_bits.push_back(b[j]);
        exp_bits.push_back(t.addr_nak);
        if (t.addr_nak) begin
            m_nak = 1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (t.rnw) begin
                b = (i == 0) ? t.rd1 : t.rd2;
                for (int j = 7; j >= 0; j--) exp_bits.push_back(b[j]);
                exp_bits.push_back(i == n - 1);
                m_rec++;
                if (i == 0) exp_b1 = b;
                else        exp_b2 = b;
            end else begin
                b = (i == 0) ? t.b1 : t.b2;
                for (int j = 7; j >= 0; j--) exp_bits.push_back(b[j]);
                nk = (t.wr_nak == i + 1);
                exp_bits.push_back(nk);
                if (nk) begin
                    m_nak++;
                    return;
                end
                m_tra++;
            end
        end
    endfunction

    // Slave pull-down for clock slot kk (9 slots per byte)
    function automatic logic drive_for(input int kk);
        int b = kk / 9;
        int p = kk % 9;
        logic [7:0] rb;
        if (b == 0) return (p == 8) && !cur.addr_nak;
        if (cur.addr_nak || b > cur_n) return 1'b0;
        if (cur.rnw) begin
            rb = (b == 1) ? cur.rd1 : cur.rd2;
            return (p < 8) ? !rb[7 - p] : 1'b0;
        end
        return (p == 8) && (cur.wr_nak != b);
    endfunction

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            slv_sda = 1'b0;
            k = 0;
            scl_q = 1'b1;
            sda_q = 1'b1;
        end else begin
            if (scl_q && scl_w && sda_q && !sda_w) begin
                n_start++;
                k = 0;
                bits.delete();
            end else if (scl_q && scl_w && !sda_q && sda_w) begin
                n_stop++;
                // clock pulse inside the stop condition is not a data bit
                if (bits.size() > 0) void'(bits.pop_back());
            end
            if (!scl_q && scl_w) begin
                bits.push_back(sda_w);
                k++;
            end
            if (scl_q && !scl_w) slv_sda = drive_for(k);
            low_run = scl_w ? 0 : low_run + 1;
            if (low_run > max_low) max_low = low_run;
            if (o_tra) n_tra++;
            if (o_rec) n_rec++;
            if (o_nak) n_nak++;
            if (int'(o_tra) + int'(o_rec) + int'(o_nak) > 1) n_ovl++;
            scl_q = scl_w;
            sda_q = sda_w;
        end
    end

    always @(negedge HCLK) begin
        if (stretch_arm && k == 12 && !scl_w) begin
            stretch_arm = 0;
            slv_scl = 1'b1;
            repeat (100) @(negedge HCLK);
            slv_scl = 1'b0;
        end
    end

    task automatic issue(input txn_t t);
        cur = t;
        cur_n = (t.nbytes == 2'd3) ? 2 : int'(t.nbytes);
        n_start = 0; n_stop = 0;
        n_tra = 0; n_rec = 0; n_nak = 0; n_ovl = 0;
        max_low = 0;
        @(negedge HCLK);
        i_slvaddr = t.addr; i_rnw = t.rnw; i_nbytes = t.nbytes;
        i_byte_1 = t.b1; i_byte_2 = t.b2;
        i_start = 1'b1;
        @(negedge HCLK);
        i_start = 1'b0;
    endtask

    task automatic run_txn(input txn_t t, input string nm, input bit stretch);
        int cyc = 0;
        int diff = 0;
        build_model(t);
        stretch_arm = stretch;
        issue(t);
        chk({nm, ".busy_rise"}, o_busy, 1);
        if (t.poke) begin
            repeat (40) @(negedge HCLK);
            i_slvaddr = 7'h7F; i_rnw = ~t.rnw; i_nbytes = 2'd2;
            i_start = 1'b1;
            @(negedge HCLK);
            i_start = 1'b0;
        end
        while (o_busy && cyc < 20000) begin
            @(negedge HCLK);
            cyc++;
        end
        chk({nm, ".timeout"}, cyc >= 20000, 0);
        chk({nm, ".nbits"}, bits.size(), exp_bits.size());
        for (int i = 0; i < bits.size() && i < exp_bits.size(); i++)
            if (bits[i] !== exp_bits[i]) diff++;
        chk({nm, ".bit_errs"}, diff, 0);
        chk({nm, ".tra"}, n_tra, t.e_tra);
        chk({nm, ".rec"}, n_rec, t.e_rec);
        chk({nm, ".nak"}, n_nak, t.e_nak);
        chk({nm, ".overlap"}, n_ovl, 0);
        chk({nm, ".byte_1"}, o_byte_1, exp_b1);
        chk({nm, ".byte_2"}, o_byte_2, exp_b2);
        chk({nm, ".lines"}, {o_scl_oe, o_sda_oe}, 0);
        if (stretch) chk({nm, ".stretch"}, max_low >= 100, 1);
        repeat (20) @(negedge HCLK);
        chk({nm, ".idle"}, o_busy, 0);
        chk({nm, ".starts"}, n_start, 1);
        chk({nm, ".stops"}, n_stop, 1);
    endtask

    txn_t tbl[9];
    txn_t r;
    int   wr;

    initial begin
        //          addr   rnw nb  b1     b2     rd1    rd2   anak wn pk tra rec nak
        tbl[0] = '{7'h50, 1'b0, 2'd2, 8'h11, 8'h22, 8'h00, 8'h00, 1'b0, 0, 1, 2, 0, 0};
        tbl[1] = '{7'h50, 1'b1, 2'd2, 8'h00, 8'h00, 8'h3C, 8'hA5, 1'b0, 0, 0, 0, 2, 0};
        tbl[2] = '{7'h7F, 1'b0, 2'd2, 8'h12, 8'h34, 8'h00, 8'h00, 1'b1, 0, 0, 0, 0, 1};
        tbl[3] = '{7'h2A, 1'b0, 2'd0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 0, 1, 0, 0, 0};
        tbl[4] = '{7'h15, 1'b0, 2'd3, 8'hAA, 8'h55, 8'h00, 8'h00, 1'b0, 0, 0, 2, 0, 0};
        tbl[5] = '{7'h33, 1'b0, 2'd2, 8'hC3, 8'h3C, 8'h00, 8'h00, 1'b0, 1, 0, 0, 0, 1};
        tbl[6] = '{7'h33, 1'b0, 2'd2, 8'h81, 8'h7E, 8'h00, 8'h00, 1'b0, 2, 0, 1, 0, 1};
        tbl[7] = '{7'h01, 1'b1, 2'd1, 8'h00, 8'h00, 8'h81, 8'h00, 1'b0, 0, 0, 0, 1, 0};
        tbl[8] = '{7'h44, 1'b1, 2'd2, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b1, 0, 0, 0, 0, 1};

        repeat (5) @(negedge HCLK);
        chk("reset_outs", {o_scl_oe, o_sda_oe, o_byte_1, o_byte_2,
                           o_tra, o_rec, o_nak, o_busy}, 0);
        HRESETn = 1'b1;
        repeat (5) @(negedge HCLK);

        for (int i = 0; i < 9; i++)
            run_txn(tbl[i], $sformatf("vec%0d", i), 1'b0);

        // slave stretches SCL in bit 3 of byte 1
        run_txn('{7'h50, 1'b0, 2'd2, 8'h11, 8'h22, 8'h00, 8'h00,
                  1'b0, 0, 0, 2, 0, 0}, "stretch", 1'b1);

        // reset in the middle of a read byte
        issue('{7'h50, 1'b1, 2'd2, 8'h00, 8'h00, 8'h5A, 8'hC3,
                1'b0, 0, 0, 0, 0, 0});
        repeat (250) @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        chk("midrst.scl_oe", o_scl_oe, 0);
        chk("midrst.sda_oe", o_sda_oe, 0);
        chk("midrst.busy", o_busy, 0);
        chk("midrst.byte_1", o_byte_1, 0);
        exp_b1 = '0;
        exp_b2 = '0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (3) @(negedge HCLK);
        run_txn('{7'h50, 1'b1, 2'd2, 8'h00, 8'h00, 8'h3C, 8'hA5,
                  1'b0, 0, 0, 0, 2, 0}, "after_rst", 1'b0);

        for (int i = 0; i < 10; i++) begin
            r.addr = 7'($urandom_range(0, 127));
            r.rnw = 1'($urandom_range(0, 1));
            r.nbytes = 2'($urandom_range(0, 3));
            r.b1 = 8'($urandom_range(0, 255));
            r.b2 = 8'($urandom_range(0, 255));
            r.rd1 = 8'($urandom_range(0, 255));
            r.rd2 = 8'($urandom_range(0, 255));
            r.addr_nak = ($urandom_range(0, 4) == 0);
            wr = int'($urandom_range(0, 4));
            r.wr_nak = (wr > 2) ? 0 : wr;
            r.poke = 1'($urandom_range(0, 1));
            build_model(r);
            r.e_tra = m_tra;
            r.e_rec = m_rec;
            r.e_nak = m_nak;
            run_txn(r, $sformatf("rnd%0d", i), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
